// File: rtl/instr_exec_unit.sv
// Sequencing execution unit: walks an inclusive, wrapping range of register
// addresses, executes each captured instruction and streams results out.
package instr_exec_pkg;
    typedef enum logic [3:0] {
        OPC_ZERO  = 4'd0,
        OPC_PASSA = 4'd1,
        OPC_PASSB = 4'd2,
        OPC_ADD   = 4'd3,
        OPC_SUB   = 4'd4,
        OPC_MULT  = 4'd5,
        OPC_DIV   = 4'd6,
        OPC_MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t     opc;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } instruction_t;
endpackage

module instr_exec_unit
    import instr_exec_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] read_pointer,
    input  instruction_t      instruction_word,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic [3:0]        res_opc,
    output logic [63:0]       res_value,
    output logic              res_err
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;

    state_t             state, state_n;
    instruction_t       ir_q;
    logic [ADDR_W-1:0]  last_q;
    logic [CNT_W-1:0]   div_cnt;

    logic signed [63:0] a64, b64, calc_val;
    logic               calc_err;
    logic               is_div, exec_done, at_last;

    // The divider is combinational; DIV_CYCLES gives it a multicycle window
    // so the path can be relaxed in timing without changing behaviour.
    always_comb begin
        a64      = {{32{ir_q.op_a[31]}}, ir_q.op_a};
        b64      = {{32{ir_q.op_b[31]}}, ir_q.op_b};
        calc_val = '0;
        calc_err = 1'b0;
        case (ir_q.opc)
            OPC_ZERO:  calc_val = '0;
            OPC_PASSA: calc_val = a64;
            OPC_PASSB: calc_val = b64;
            OPC_ADD:   calc_val = a64 + b64;
            OPC_SUB:   calc_val = a64 - b64;
            OPC_MULT:  calc_val = a64 * b64;
            OPC_DIV: begin
                if (b64 == 64'sd0) calc_err = 1'b1;
                else               calc_val = a64 / b64;
            end
            OPC_MOD: begin
                if (b64 == 64'sd0) calc_err = 1'b1;
                else               calc_val = a64 % b64;
            end
            default:   calc_err = 1'b1;
        endcase
    end

    assign is_div    = (ir_q.opc == OPC_DIV) || (ir_q.opc == OPC_MOD);
    assign exec_done = !is_div || (div_cnt == CNT_W'(DIV_CYCLES - 1));
    assign at_last   = (read_pointer == last_q);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_FETCH;
            S_FETCH: state_n = S_EXEC;
            S_EXEC:  if (exec_done) state_n = S_OUT;
            S_OUT:   if (res_ready) state_n = at_last ? S_DONE : S_FETCH;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            read_pointer <= '0;
            last_q       <= '0;
            ir_q         <= '0;
            div_cnt      <= '0;
            res_addr     <= '0;
            res_opc      <= '0;
            res_value    <= '0;
            res_err      <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        read_pointer <= first_addr;
                        last_q       <= last_addr;
                    end
                end
                S_FETCH: begin
                    ir_q    <= instruction_word;
                    div_cnt <= '0;
                end
                S_EXEC: begin
                    div_cnt <= div_cnt + CNT_W'(1);
                    // Results are loaded once on entry to OUT and then held
                    // untouched for the whole handshake.
                    if (exec_done) begin
                        res_addr  <= read_pointer;
                        res_opc   <= ir_q.opc;
                        res_value <= calc_val;
                        res_err   <= calc_err;
                    end
                end
                S_OUT: begin
                    if (res_ready && !at_last)
                        read_pointer <= read_pointer + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign res_valid = (state == S_OUT);
endmodule
